// File: rtl/drrip_policy_engine_if.sv
// Request/response bundle between the cache controller (master) and the DRRIP engine (slave).
interface drrip_policy_engine_if #(
    parameter int NUM_WAYS  = 16,
    parameter int NUM_SETS  = 128,
    parameter int RRPV_BITS = 2,
    parameter int PSEL_BITS = 10
);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int SET_W = $clog2(NUM_SETS);

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_hit;
    logic [SET_W-1:0]     req_set;
    logic [WAY_W-1:0]     req_way;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [WAY_W-1:0]     resp_way;
    logic [RRPV_BITS-1:0] resp_rrpv;
    logic                 resp_srrip;
    logic [PSEL_BITS-1:0] psel_value;

    modport master (
        output req_valid, req_hit, req_set, req_way, resp_ready,
        input  req_ready, resp_valid, resp_way, resp_rrpv, resp_srrip, psel_value
    );

    modport slave (
        input  req_valid, req_hit, req_set, req_way, resp_ready,
        output req_ready, resp_valid, resp_way, resp_rrpv, resp_srrip, psel_value
    );
endinterface

// File: rtl/drrip_policy_engine.sv
// DRRIP replacement engine: single-cycle bulk aging on miss, set dueling with saturating PSEL.
// Define DRRIP_HP_EN for hit priority (hit sets RRPV to 0); default is frequency priority.
module drrip_policy_engine #(
    parameter int NUM_WAYS     = 16,
    parameter int NUM_SETS     = 128,
    parameter int RRPV_BITS    = 2,
    parameter int PSEL_BITS    = 10,
    parameter int SDM_STRIDE   = 32,
    parameter int BIP_EPS_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    drrip_policy_engine_if.slave  bus
);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int SET_W = $clog2(NUM_SETS);

    localparam logic [RRPV_BITS-1:0] RRPV_MAX  = '1;
    localparam logic [RRPV_BITS-1:0] RRPV_LONG = RRPV_MAX - RRPV_BITS'(1);
    localparam logic [PSEL_BITS-1:0] PSEL_MAX  = '1;
    localparam logic [PSEL_BITS-1:0] PSEL_INIT = PSEL_BITS'(1) << (PSEL_BITS - 1);
    localparam logic [SET_W-1:0]     SDM_MASK  = SET_W'(SDM_STRIDE - 1);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t                  state_q, state_d;
    logic [RRPV_BITS-1:0]    rrpv_q [NUM_SETS][NUM_WAYS];
    logic [PSEL_BITS-1:0]    psel_q;
    logic [BIP_EPS_LOG2-1:0] bip_cnt_q;
    logic [SET_W-1:0]        set_q;
    logic                    srrip_q;
    logic [WAY_W-1:0]        resp_way_q;
    logic [RRPV_BITS-1:0]    resp_rrpv_q;
    logic                    resp_srrip_q;

    logic                    hit_accept, miss_accept;
    logic [SET_W-1:0]        sdm_off;
    logic                    srrip_leader, bip_leader, req_use_srrip;
    logic [RRPV_BITS-1:0]    row_max, delta, ins_rrpv;
    logic [RRPV_BITS-1:0]    aged [NUM_WAYS];
    logic [WAY_W-1:0]        victim;

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_way   = resp_way_q;
    assign bus.resp_rrpv  = resp_rrpv_q;
    assign bus.resp_srrip = resp_srrip_q;
    assign bus.psel_value = psel_q;

    assign hit_accept  = bus.req_valid && bus.req_ready &&  bus.req_hit;
    assign miss_accept = bus.req_valid && bus.req_ready && !bus.req_hit;

    assign sdm_off       = bus.req_set & SDM_MASK;
    assign srrip_leader  = (sdm_off == '0);
    assign bip_leader    = (sdm_off == SDM_MASK);
    assign req_use_srrip = srrip_leader || (!bip_leader && psel_q[PSEL_BITS-1]);

    // Bulk aging: lift the whole set by the distance of its oldest way from RRPV_MAX,
    // so at least one way is guaranteed to reach RRPV_MAX in this same cycle.
    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment so no latch is inferred.
        row_max  = '0;
        victim   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (rrpv_q[set_q][w] > row_max) row_max = rrpv_q[set_q][w];
        end
        delta = RRPV_MAX - row_max;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            aged[w] = rrpv_q[set_q][w] + delta;
            if (aged[w] == RRPV_MAX) victim = WAY_W'(w);
        end
        ins_rrpv = (srrip_q || bip_cnt_q == '0) ? RRPV_LONG : RRPV_MAX;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss_accept) state_d = SCAN;
            SCAN:    state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psel_q       <= PSEL_INIT;
            bip_cnt_q    <= '0;
            set_q        <= '0;
            srrip_q      <= 1'b0;
            resp_way_q   <= '0;
            resp_rrpv_q  <= '0;
            resp_srrip_q <= 1'b0;
        end else begin
            if (miss_accept) begin
                set_q   <= bus.req_set;
                srrip_q <= req_use_srrip;
                if (srrip_leader && psel_q != '0)          psel_q <= psel_q - PSEL_BITS'(1);
                else if (bip_leader && psel_q != PSEL_MAX) psel_q <= psel_q + PSEL_BITS'(1);
            end
            if (state_q == SCAN) begin
                resp_way_q   <= victim;
                resp_rrpv_q  <= ins_rrpv;
                resp_srrip_q <= srrip_q;
                if (!srrip_q) bip_cnt_q <= bip_cnt_q + BIP_EPS_LOG2'(1);
            end
        end
    end

    // Hits and insertions never collide: hits are only accepted in IDLE, inserts only happen in SCAN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the RRPV array is real policy state (all ways start as distant), so it is reset like any flop.
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) rrpv_q[s][w] <= RRPV_MAX;
            end
        end else if (hit_accept) begin
`ifdef DRRIP_HP_EN
            rrpv_q[bus.req_set][bus.req_way] <= '0;
`else
            if (rrpv_q[bus.req_set][bus.req_way] != '0)
                rrpv_q[bus.req_set][bus.req_way] <= rrpv_q[bus.req_set][bus.req_way] - RRPV_BITS'(1);
`endif
        end else if (state_q == SCAN) begin
            for (int w = 0; w < NUM_WAYS; w++) rrpv_q[set_q][w] <= aged[w];
            rrpv_q[set_q][victim] <= ins_rrpv;
        end
    end
endmodule

// File: tb/tb_drrip_policy_engine.sv
// Directed self-checking bench for drrip_policy_engine at default parameters.
module tb_drrip_policy_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

`ifdef DRRIP_HP_EN
    localparam logic [1:0] HIT1 = 2'd0;
`else
    localparam logic [1:0] HIT1 = 2'd1;
`endif

    drrip_policy_engine_if bus ();
    drrip_policy_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic do_reset();
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_hit = 1'b0; bus.req_set = '0; bus.req_way = '0;
        bus.resp_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_resp(input string name);
        int n = 0;
        while (bus.resp_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (bus.resp_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s_resp_timeout resp_valid got %b exp 1", name, bus.resp_valid);
        end
    endtask

    task automatic do_miss(input logic [6:0] set, output logic [3:0] way, output logic [1:0] rrpv,
                           output logic srrip, output int lat);
        int n = 0;
        bus.req_valid = 1'b1; bus.req_hit = 1'b0; bus.req_set = set; bus.req_way = '0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (bus.req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL miss_req_timeout req_ready got %b exp 1", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (bus.resp_valid !== 1'b1) begin
            checks++; errors++; lat = -1;
            $display("FAIL miss_resp_timeout resp_valid got %b exp 1", bus.resp_valid);
        end
        way = bus.resp_way; rrpv = bus.resp_rrpv; srrip = bus.resp_srrip;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake got ready=%b valid=%b exp ready=1 valid=0", bus.req_ready, bus.resp_valid);
        end
        checks++;
        if (bus.resp_way !== 4'd0 || bus.resp_rrpv !== 2'd0 || bus.resp_srrip !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp got way=%0d rrpv=%0d srrip=%b exp 0/0/0", bus.resp_way, bus.resp_rrpv, bus.resp_srrip);
        end
        checks++;
        if (bus.psel_value !== 10'd512) begin
            errors++; $display("FAIL reset_psel got %0d exp 512", bus.psel_value);
        end
    endtask

    task automatic test_first_miss();
        logic [3:0] way; logic [1:0] rrpv; logic srrip; int lat;
        do_miss(7'd5, way, rrpv, srrip, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL first_miss_latency got %0d exp 1", lat); end
        checks++;
        if (way !== 4'd0 || rrpv !== 2'd2 || srrip !== 1'b1) begin
            errors++; $display("FAIL first_miss_resp got way=%0d rrpv=%0d srrip=%b exp 0/2/1", way, rrpv, srrip);
        end
        checks++;
        if (bus.psel_value !== 10'd512) begin
            errors++; $display("FAIL first_miss_psel got %0d exp 512", bus.psel_value);
        end
    endtask

    task automatic test_fill_and_age();
        logic [3:0] way; logic [1:0] rrpv; logic srrip; int lat; int bad;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_miss(7'd5, way, rrpv, srrip, lat);
            checks++;
            if (way !== 4'(i) || rrpv !== 2'd2) begin
                errors++; $display("FAIL fill_victim_%0d got way=%0d rrpv=%0d exp way=%0d rrpv=2", i, way, rrpv, i);
            end
        end
        bad = 0;
        for (int w = 0; w < 16; w++) if (dut.rrpv_q[5][w] !== 2'd2) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL fill_all_long got %0d ways not at 2 exp 0", bad); end
        do_miss(7'd5, way, rrpv, srrip, lat);
        checks++;
        if (way !== 4'd0 || rrpv !== 2'd2) begin
            errors++; $display("FAIL aged_miss_resp got way=%0d rrpv=%0d exp 0/2", way, rrpv);
        end
        bad = 0;
        if (dut.rrpv_q[5][0] !== 2'd2) bad++;
        for (int w = 1; w < 16; w++) if (dut.rrpv_q[5][w] !== 2'd3) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL aged_set_state got %0d wrong ways exp 0", bad); end
    endtask

    task automatic test_hit();
        logic [3:0] way; logic [1:0] rrpv; logic srrip; int lat;
        logic [3:0] seq [5] = '{4'd3, 4'd4, 4'd5, 4'd5, 4'd5};
        do_reset();
        for (int i = 0; i < 16; i++) do_miss(7'd5, way, rrpv, srrip, lat);
        bus.req_valid = 1'b1; bus.req_hit = 1'b1; bus.req_set = 7'd5; bus.req_way = 4'd3;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checks++;
        if (dut.rrpv_q[5][3] !== HIT1) begin
            errors++; $display("FAIL hit_first got %0d exp %0d", dut.rrpv_q[5][3], HIT1);
        end
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.req_way = seq[i];
            checks++;
            if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL hit_b2b_ready_%0d got %b exp 1", i, bus.req_ready); end
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0; bus.req_hit = 1'b0;
        checks++;
        if (dut.rrpv_q[5][3] !== 2'd0 || dut.rrpv_q[5][4] !== HIT1 || dut.rrpv_q[5][5] !== 2'd0) begin
            errors++;
            $display("FAIL hit_b2b_state got w3=%0d w4=%0d w5=%0d exp 0/%0d/0",
                     dut.rrpv_q[5][3], dut.rrpv_q[5][4], dut.rrpv_q[5][5], HIT1);
        end
    endtask

    task automatic test_psel_srrip_leader();
        logic [3:0] way; logic [1:0] rrpv; logic srrip; int lat;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_miss(7'd0, way, rrpv, srrip, lat);
            checks++;
            if (srrip !== 1'b1) begin errors++; $display("FAIL srrip_leader_policy_%0d got %b exp 1", i, srrip); end
        end
        checks++;
        if (bus.psel_value !== 10'd509) begin errors++; $display("FAIL psel_dec got %0d exp 509", bus.psel_value); end
        // PSEL MSB now 0: followers switch to BIP and consume bip_cnt (0 then 1).
        do_miss(7'd5, way, rrpv, srrip, lat);
        checks++;
        if (srrip !== 1'b0 || rrpv !== 2'd2) begin
            errors++; $display("FAIL follower_bip_1 got srrip=%b rrpv=%0d exp 0/2", srrip, rrpv);
        end
        do_miss(7'd5, way, rrpv, srrip, lat);
        checks++;
        if (srrip !== 1'b0 || rrpv !== 2'd3 || bus.psel_value !== 10'd509) begin
            errors++; $display("FAIL follower_bip_2 got srrip=%b rrpv=%0d psel=%0d exp 0/3/509", srrip, rrpv, bus.psel_value);
        end
    endtask

    task automatic test_bip_epsilon();
        logic [3:0] way; logic [1:0] rrpv; logic srrip; int lat;
        logic [1:0] exp_rrpv;
        do_reset();
        for (int i = 1; i <= 33; i++) begin
            do_miss(7'd31, way, rrpv, srrip, lat);
            exp_rrpv = (i == 1 || i == 33) ? 2'd2 : 2'd3;
            checks++;
            if (rrpv !== exp_rrpv || srrip !== 1'b0) begin
                errors++; $display("FAIL bip_insert_%0d got rrpv=%0d srrip=%b exp %0d/0", i, rrpv, srrip, exp_rrpv);
            end
        end
        checks++;
        if (bus.psel_value !== 10'd545) begin errors++; $display("FAIL bip_psel_inc got %0d exp 545", bus.psel_value); end
    endtask

    task automatic test_psel_saturation();
        logic [3:0] way; logic [1:0] rrpv; logic srrip; int lat;
        for (int i = 0; i < 567; i++) do_miss(7'd31, way, rrpv, srrip, lat);
        checks++;
        if (bus.psel_value !== 10'd1023) begin errors++; $display("FAIL psel_sat got %0d exp 1023", bus.psel_value); end
        do_miss(7'd5, way, rrpv, srrip, lat);
        checks++;
        if (srrip !== 1'b1 || rrpv !== 2'd2 || way !== 4'd0) begin
            errors++; $display("FAIL follower_srrip got srrip=%b rrpv=%0d way=%0d exp 1/2/0", srrip, rrpv, way);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] way; logic [1:0] rrpv; logic srrip; int lat;
        do_reset();
        do_miss(7'd5, way, rrpv, srrip, lat);
        bus.req_valid = 1'b1; bus.req_hit = 1'b0; bus.req_set = 7'd5;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_resp("backpressure");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.resp_way !== 4'd1 ||
                bus.resp_rrpv !== 2'd2 || bus.resp_srrip !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold_%0d got v=%b rdy=%b way=%0d rrpv=%0d srrip=%b exp 1/0/1/2/1",
                         i, bus.resp_valid, bus.req_ready, bus.resp_way, bus.resp_rrpv, bus.resp_srrip);
            end
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL backpressure_release got v=%b rdy=%b exp 0/1", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] way; logic [1:0] rrpv; logic srrip; int lat;
        do_reset();
        do_miss(7'd5, way, rrpv, srrip, lat);
        bus.req_valid = 1'b1; bus.req_hit = 1'b0; bus.req_set = 7'd0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checks++;
        if (bus.psel_value !== 10'd511) begin errors++; $display("FAIL mid_psel_before got %0d exp 511", bus.psel_value); end
        wait_resp("reset_mid");
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.psel_value !== 10'd512) begin
            errors++;
            $display("FAIL mid_reset_async got v=%b rdy=%b psel=%0d exp 0/1/512", bus.resp_valid, bus.req_ready, bus.psel_value);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_miss(7'd5, way, rrpv, srrip, lat);
        checks++;
        if (way !== 4'd0 || bus.psel_value !== 10'd512) begin
            errors++; $display("FAIL mid_reset_after got way=%0d psel=%0d exp 0/512", way, bus.psel_value);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_hit = 1'b0; bus.req_set = '0; bus.req_way = '0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_first_miss();
        test_fill_and_age();
        test_hit();
        test_psel_srrip_leader();
        test_bip_epsilon();
        test_psel_saturation();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
